// File: rtl/cache_mem_responder_if.sv
// rtl/cache_mem_responder_if.sv - request/return channel between a cache controller and its backing memory
//
// Signals:
//   req, addr, wdata, we  requester -> responder request (held while req & !gnt)
//   gnt                   responder -> requester, request accepted this cycle
//   valid, rdata          responder -> requester read return beat
//   ready                 requester -> responder, return beat accepted
// Modports: master = requester side, slave = responder side.
interface cache_mem_responder_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64
);
    logic                  req;
    logic                  gnt;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  we;
    logic                  valid;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  ready;

    modport master (
        output req, addr, wdata, we, ready,
        input  gnt, valid, rdata
    );

    modport slave (
        input  req, addr, wdata, we, ready,
        output gnt, valid, rdata
    );
endinterface

// File: rtl/cache_mem_responder.sv
// rtl/cache_mem_responder.sv - backing-memory responder with fixed read latency and bounded outstanding reads
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset; clears counter, pipeline, FIFO and the whole array
//   bus    cache_mem_responder_if.slave: req/gnt/addr/wdata/we request side,
//          valid/rdata/ready in-order read return side
module cache_mem_responder #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 64,
    parameter int MEM_DEPTH   = 256,
    parameter int RD_LATENCY  = 2,
    parameter int OUTSTANDING = 4
) (
    input  logic clk,
    input  logic rst_n,
    cache_mem_responder_if.slave bus
);
    localparam int OFF_W = $clog2(DATA_WIDTH / 8);
    localparam int IDX_W = $clog2(MEM_DEPTH);
    localparam int CNT_W = $clog2(OUTSTANDING + 1);
    localparam int PTR_W = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;

    logic [DATA_WIDTH-1:0] mem       [MEM_DEPTH];
    logic [DATA_WIDTH-1:0] pipe_data [RD_LATENCY];
    logic [RD_LATENCY-1:0] pipe_vld;
    logic [DATA_WIDTH-1:0] fifo_mem  [OUTSTANDING];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      fifo_cnt;
    logic [CNT_W-1:0]      rd_cnt;
    logic [DATA_WIDTH-1:0] last_rdata;

    logic [IDX_W-1:0] idx;
    logic             gnt_int;
    logic             rd_acc;
    logic             wr_acc;
    logic             push;
    logic             pop;
    logic             fifo_ne;

    assign idx     = bus.addr[OFF_W +: IDX_W];
    // rd_cnt is registered, so a pop at full only re-opens reads next cycle.
    // rst_n gates the grant so it drops the instant reset is asserted.
    assign gnt_int = rst_n & bus.req & (bus.we | (rd_cnt < CNT_W'(OUTSTANDING)));
    assign rd_acc  = gnt_int & ~bus.we;
    assign wr_acc  = gnt_int & bus.we;
    assign push    = pipe_vld[RD_LATENCY-1];
    assign fifo_ne = (fifo_cnt != '0);
    assign pop     = fifo_ne & bus.ready;

    assign bus.gnt   = gnt_int;
    assign bus.valid = fifo_ne;
    // Once drained, the last popped beat stays on rdata instead of a stale FIFO slot.
    assign bus.rdata = fifo_ne ? fifo_mem[rd_ptr] : last_rdata;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(OUTSTANDING - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
            for (int k = 0; k < RD_LATENCY; k++) pipe_data[k] <= '0;
            for (int j = 0; j < OUTSTANDING; j++) fifo_mem[j] <= '0;
            pipe_vld   <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_cnt   <= '0;
            rd_cnt     <= '0;
            last_rdata <= '0;
        end else begin
            if (wr_acc) mem[idx] <= bus.wdata;

            // Stage 0 samples the array before any same-edge write lands; only
            // one request is accepted per edge so the two never collide.
            pipe_data[0] <= mem[idx];
            pipe_vld[0]  <= rd_acc;
            for (int k = 1; k < RD_LATENCY; k++) begin
                pipe_data[k] <= pipe_data[k-1];
                pipe_vld[k]  <= pipe_vld[k-1];
            end

            // The outstanding bound guarantees room, so push never checks full.
            if (push) begin
                fifo_mem[wr_ptr] <= pipe_data[RD_LATENCY-1];
                wr_ptr           <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr     <= next_ptr(rd_ptr);
                last_rdata <= fifo_mem[rd_ptr];
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase

            case ({rd_acc, pop})
                2'b10:   rd_cnt <= rd_cnt + CNT_W'(1);
                2'b01:   rd_cnt <= rd_cnt - CNT_W'(1);
                default: rd_cnt <= rd_cnt;
            endcase
        end
    end
endmodule

// File: tb/tb_cache_mem_responder.sv
// tb/tb_cache_mem_responder.sv - self-checking bench for cache_mem_responder
module tb_cache_mem_responder;
    localparam int AW   = 32;
    localparam int DW   = 64;
    localparam int DEPTH = 256;
    localparam int LAT  = 2;
    localparam int OUTS = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cache_mem_responder_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    cache_mem_responder #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH(DEPTH),
        .RD_LATENCY(LAT), .OUTSTANDING(OUTS)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: word array, reads waiting out their latency, return queue.
    typedef struct {
        logic [DW-1:0] data;
        longint        due;
    } pend_t;

    logic [DW-1:0] m_mem [DEPTH];
    pend_t         pend_q[$];
    logic [DW-1:0] ret_q[$];
    int            m_cnt;
    longint        cyc;

    function automatic int widx(input logic [AW-1:0] a);
        return int'((a / (DW / 8)) % DEPTH);
    endfunction

    function automatic bit exp_gnt();
        return rst_n && bus.req && (bus.we || m_cnt < OUTS);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
            pend_q.delete();
            ret_q.delete();
            m_cnt = 0;
            cyc = 0;
        end else begin
            bit    g;
            pend_t p;
            g = exp_gnt();
            cyc++;
            if (ret_q.size() > 0 && bus.ready) begin
                void'(ret_q.pop_front());
                m_cnt--;
            end
            if (g) begin
                if (bus.we) begin
                    m_mem[widx(bus.addr)] = bus.wdata;
                end else begin
                    p.data = m_mem[widx(bus.addr)];
                    p.due  = cyc + LAT;
                    pend_q.push_back(p);
                    m_cnt++;
                end
            end
            while (pend_q.size() > 0 && pend_q[0].due == cyc) begin
                p = pend_q.pop_front();
                ret_q.push_back(p.data);
            end
        end
    end

    // Continuous monitor against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            check("mon_gnt", 64'(bus.gnt), 64'(exp_gnt()));
            check("mon_valid", 64'(bus.valid), 64'(ret_q.size() > 0));
            if (bus.valid && ret_q.size() > 0)
                check("mon_rdata", bus.rdata, ret_q[0]);
        end
    end

    task automatic drive(input bit r, input bit w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input bit rdy);
        bus.req = r; bus.we = w; bus.addr = a; bus.wdata = d; bus.ready = rdy;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        drive(0, 0, '0, '0, 1);
        repeat (12) step();
    endtask

    // Leaves the caller at a negedge.
    task automatic wait_valid(input string name);
        int n = 0;
        @(negedge clk);
        while (!bus.valid && n < 30) begin
            step();
            @(negedge clk);
            n++;
        end
        check(name, 64'(bus.valid), 64'd1);
    endtask

    typedef struct {
        bit            req;
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        bit            ready;
        bit            e_gnt;
        bit            e_valid;
        logic [DW-1:0] e_rdata;
    } vec_t;

    vec_t          vt[14];
    logic [DW-1:0] tv[8];
    logic [DW-1:0] seen[$];
    logic [DW-1:0] last_w;
    bit            rdy;
    bit            g;
    bit            held;
    int            idx;
    int            guard;

    initial begin
        vt[0]  = '{1, 1, 32'h40,  64'hDEADBEEF00000001, 1, 1, 0, 64'h0};
        vt[1]  = '{1, 0, 32'h40,  64'h0, 1, 1, 0, 64'h0};
        vt[2]  = '{0, 0, 32'h0,   64'h0, 1, 0, 0, 64'h0};
        vt[3]  = '{0, 0, 32'h0,   64'h0, 1, 0, 0, 64'h0};
        vt[4]  = '{0, 0, 32'h0,   64'h0, 1, 0, 1, 64'hDEADBEEF00000001};
        vt[5]  = '{0, 0, 32'h0,   64'h0, 1, 0, 0, 64'h0};
        vt[6]  = '{1, 0, 32'h0,   64'h0, 1, 1, 0, 64'h0};
        vt[7]  = '{1, 0, 32'h7F8, 64'h0, 1, 1, 0, 64'h0};
        vt[8]  = '{1, 1, 32'h0,   64'h55, 1, 1, 0, 64'h0};
        vt[9]  = '{1, 0, 32'h800, 64'h0, 1, 1, 1, 64'h0};
        vt[10] = '{0, 0, 32'h0,   64'h0, 1, 0, 1, 64'h0};
        vt[11] = '{0, 0, 32'h0,   64'h0, 1, 0, 0, 64'h0};
        vt[12] = '{0, 0, 32'h0,   64'h0, 1, 0, 1, 64'h55};
        vt[13] = '{0, 0, 32'h0,   64'h0, 1, 0, 0, 64'h0};

        // Reset state, with req raised so gnt=0 means something.
        drive(1, 0, 32'h40, '0, 1);
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_gnt", 64'(bus.gnt), 64'd0);
        check("rst_valid", 64'(bus.valid), 64'd0);
        check("rst_rdata", bus.rdata, 64'd0);
        step();
        step();
        rst_n = 1'b1;

        // Latency, write-then-read and aliasing vectors.
        for (int i = 0; i < 14; i++) begin
            drive(vt[i].req, vt[i].we, vt[i].addr, vt[i].wdata, vt[i].ready);
            @(negedge clk);
            check($sformatf("vec%0d_gnt", i), 64'(bus.gnt), 64'(vt[i].e_gnt));
            check($sformatf("vec%0d_valid", i), 64'(bus.valid), 64'(vt[i].e_valid));
            if (vt[i].e_valid)
                check($sformatf("vec%0d_rdata", i), bus.rdata, vt[i].e_rdata);
            step();
        end

        // Outstanding limit, writes during full backpressure, late re-grant.
        for (int i = 0; i < 5; i++) begin
            drive(1, 1, 32'h200 + i * 8, 64'hA000 + i, 1);
            step();
        end
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 32'h200 + i * 8, '0, 0);
            @(negedge clk);
            check("bp_gnt_first4", 64'(bus.gnt), 64'd1);
            step();
        end
        for (int i = 0; i < 3; i++) begin
            last_w = 64'hB0B0_0000 + i;
            drive(1, 1, 32'h100, last_w, 0);
            @(negedge clk);
            check("bp_write_gnt", 64'(bus.gnt), 64'd1);
            step();
        end
        drive(1, 0, 32'h220, '0, 0);
        repeat (2) begin
            @(negedge clk);
            check("bp_gnt_5th", 64'(bus.gnt), 64'd0);
            step();
        end
        bus.ready = 1'b1;
        @(negedge clk);
        check("bp_pop_cycle_gnt", 64'(bus.gnt), 64'd0);
        check("bp_pop_cycle_valid", 64'(bus.valid), 64'd1);
        check("bp_first_beat", bus.rdata, 64'hA000);
        step();
        @(negedge clk);
        check("bp_regrant", 64'(bus.gnt), 64'd1);
        step();
        drain();
        drive(1, 0, 32'h100, '0, 1);
        step();
        drive(0, 0, '0, '0, 1);
        wait_valid("wr100_timeout");
        check("wr100_last", bus.rdata, last_w);
        step();
        drain();

        // Toggling ready over 8 reads of distinct pre-written words.
        for (int i = 0; i < 8; i++) begin
            tv[i] = {$urandom, $urandom};
            drive(1, 1, 32'h300 + i * 8, tv[i], 1);
            step();
        end
        drive(0, 0, '0, '0, 1);
        step();
        seen.delete();
        idx = 0; guard = 0; rdy = 0;
        while (idx < 8 && guard < 100) begin
            drive(1, 0, 32'h300 + idx * 8, '0, rdy);
            @(negedge clk);
            if (bus.valid && bus.ready) seen.push_back(bus.rdata);
            g = exp_gnt();
            step();
            if (g) idx++;
            rdy = !rdy;
            guard++;
        end
        bus.req = 1'b0;
        guard = 0;
        while (seen.size() < 8 && guard < 100) begin
            bus.ready = rdy;
            @(negedge clk);
            if (bus.valid && bus.ready) seen.push_back(bus.rdata);
            step();
            rdy = !rdy;
            guard++;
        end
        check("toggle_beats", 64'(seen.size()), 64'd8);
        for (int k = 0; k < 8 && k < seen.size(); k++)
            check($sformatf("toggle_order%0d", k), seen[k], tv[k]);
        bus.ready = 1'b1;
        repeat (3) step();
        @(negedge clk);
        check("toggle_no_extra", 64'(bus.valid), 64'd0);
        step();

        // Randomized mix, honouring the hold rule.
        held = 0;
        for (int c = 0; c < 1500; c++) begin
            if (!held) begin
                drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                      32'($urandom_range(0, 63) * 8 + $urandom_range(0, 7)
                          + ($urandom_range(0, 1) ? 32'h800 : 32'h0)),
                      {$urandom, $urandom}, 1'b0);
            end
            bus.ready = ($urandom_range(0, 9) < 6);
            @(negedge clk);
            held = bus.req && !exp_gnt();
            step();
        end
        drain();

        // Reset with reads in flight.
        drive(1, 1, 32'h40, 64'h1234, 1);
        step();
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 32'h40, '0, 0);
            step();
        end
        drive(0, 0, '0, '0, 0);
        wait_valid("inflight_timeout");
        step();
        drive(1, 0, 32'h40, '0, 0);
        rst_n = 1'b0;
        #1;
        check("midrst_valid", 64'(bus.valid), 64'd0);
        check("midrst_gnt", 64'(bus.gnt), 64'd0);
        step();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(1, 0, 32'h40, '0, 0);
            @(negedge clk);
            check("postrst_gnt", 64'(bus.gnt), 64'(i < 4));
            step();
        end
        bus.ready = 1'b1;
        @(negedge clk);
        check("postrst_valid", 64'(bus.valid), 64'd1);
        check("postrst_data", bus.rdata, 64'd0);
        step();
        @(negedge clk);
        check("postrst_regrant", 64'(bus.gnt), 64'd1);
        step();
        drain();
        @(negedge clk);
        check("final_idle", 64'(bus.valid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
